// File: rtl/conv_sched_pkg.sv
// Shared types and defaults for the conv pass scheduler and its watchdog.
package conv_sched_pkg;

  // Job sequencing states.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_IMG = 3'd1,
    RUN      = 3'd2,
    DONE     = 3'd3,
    ERROR    = 3'd4
  } sched_state_e;

  // Default geometry: 28x28 image, 5x5 kernel -> 24 output columns.
  localparam int DEF_OUT_COLS       = 24;
  localparam int DEF_MAX_PASSES     = 16;
  localparam int DEF_ADDR_W         = 12;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  // Width of a counter that must be able to hold the value max_value itself.
  function automatic int cnt_width(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/conv_sched_watchdog.sv
// Stall watchdog: saturating cycle counter, cleared on activity, that flags
// the cycle on which it would reach TIMEOUT so the caller can react on the
// same clock edge the count completes.
module conv_sched_watchdog
  import conv_sched_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and hold at TIMEOUT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Expiry is signalled while the final counted cycle is in progress.
  assign expire_o = inc_i && !clr_i && (cnt_q == CNT_LAST);

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/conv_pass_scheduler.sv
// Conv pass scheduler: runs the conv core once per image pass, handshaking
// image banks with the PS loader, generating per-pass BRAM base addresses,
// tagging output columns for writeback and supervising completion.
module conv_pass_scheduler
  import conv_sched_pkg::*;
#(
  parameter int OUT_COLS       = DEF_OUT_COLS,
  parameter int MAX_PASSES     = DEF_MAX_PASSES,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_start,
  input  logic                            cmd_abort,
  input  logic [$clog2(MAX_PASSES+1)-1:0] cfg_num_passes,
  input  logic [ADDR_W-1:0]               cfg_base_addr,
  input  logic [ADDR_W-1:0]               cfg_pass_stride,
  input  logic                            img_valid,
  output logic                            img_ack,
  output logic                            conv_start,
  output logic                            conv_soft_rst,
  output logic [ADDR_W-1:0]               conv_base_addr,
  input  logic                            conv_valid_col,
  input  logic                            conv_done,
  output logic                            col_we,
  output logic [$clog2(OUT_COLS)-1:0]     col_idx,
  output logic [$clog2(MAX_PASSES)-1:0]   pass_idx,
  output logic                            busy,
  output logic                            job_done,
  output logic                            err_timeout,
  output logic                            err_col_count
);

  localparam int NP_W = cnt_width(MAX_PASSES);
  localparam int CC_W = cnt_width(OUT_COLS);
  localparam int CI_W = $clog2(OUT_COLS);
  localparam int PI_W = $clog2(MAX_PASSES);
  localparam logic [CC_W-1:0] COLS_FULL = CC_W'(OUT_COLS);

  sched_state_e      state_q, state_d;
  logic [NP_W-1:0]   num_passes_q, num_passes_d;
  logic [NP_W-1:0]   pass_q, pass_d, pass_inc;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CC_W-1:0]   col_cnt_q, col_cnt_d;
  logic [CC_W:0]     col_final;
  logic              conv_start_q, conv_start_d;
  logic              img_ack_q, img_ack_d;
  logic              soft_rst_q, soft_rst_d;
  logic              zero_done_q, zero_done_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_col_q, err_col_d;
  logic              in_run, wd_clr, wd_expire;

  // Watchdog only runs in RUN; leaving RUN (including the WAIT_IMG->RUN
  // entry) or any core activity restarts it.
  assign in_run = (state_q == RUN);
  assign wd_clr = !in_run || conv_valid_col || conv_done;

  conv_sched_watchdog #(
    .TIMEOUT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (wd_clr),
    .inc_i    (in_run),
    .expire_o (wd_expire)
  );

  // Next-state and output decode; abort overrides every other event.
  always_comb begin
    state_d       = state_q;
    num_passes_d  = num_passes_q;
    pass_d        = pass_q;
    stride_d      = stride_q;
    addr_d        = addr_q;
    col_cnt_d     = col_cnt_q;
    conv_start_d  = 1'b0;
    img_ack_d     = 1'b0;
    soft_rst_d    = 1'b0;
    zero_done_d   = 1'b0;
    err_timeout_d = err_timeout_q;
    err_col_d     = err_col_q;

    pass_inc  = pass_q + NP_W'(1);
    // Columns seen this pass if the core finishes now; a column arriving
    // together with done still counts.
    col_final = {1'b0, col_cnt_q} + {{CC_W{1'b0}}, conv_valid_col};
    col_we    = in_run && conv_valid_col && (col_cnt_q < COLS_FULL);

    if (cmd_abort) begin
      state_d       = IDLE;
      soft_rst_d    = 1'b1;
      err_timeout_d = 1'b0;
      err_col_d     = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_start) begin
            num_passes_d = cfg_num_passes;
            stride_d     = cfg_pass_stride;
            addr_d       = cfg_base_addr;
            pass_d       = '0;
            col_cnt_d    = '0;
            err_col_d    = 1'b0;
            if (cfg_num_passes == '0) begin
              zero_done_d = 1'b1;
            end else begin
              state_d = WAIT_IMG;
            end
          end
        end
        WAIT_IMG: begin
          if (img_valid) begin
            conv_start_d = 1'b1;
            col_cnt_d    = '0;
            state_d      = RUN;
          end
        end
        RUN: begin
          if (col_we) begin
            col_cnt_d = col_cnt_q + CC_W'(1);
          end
          // Strobe beyond the expected column count is dropped and flagged.
          if (conv_valid_col && !col_we) begin
            err_col_d = 1'b1;
          end
          if (conv_done) begin
            if (col_final != {1'b0, COLS_FULL}) begin
              err_col_d = 1'b1;
            end
            img_ack_d = 1'b1;
            pass_d    = pass_inc;
            if (pass_inc == num_passes_q) begin
              state_d = DONE;
            end else begin
              // Running sum equals base + pass*stride, wrapping at 2^ADDR_W.
              addr_d  = addr_q + stride_q;
              state_d = WAIT_IMG;
            end
          end else if (wd_expire) begin
            err_timeout_d = 1'b1;
            state_d       = ERROR;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        ERROR: begin
          state_d = ERROR;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    img_ack        = img_ack_q;
    conv_start     = conv_start_q;
    conv_soft_rst  = soft_rst_q;
    conv_base_addr = addr_q;
    col_idx        = col_cnt_q[CI_W-1:0];
    pass_idx       = pass_q[PI_W-1:0];
    busy           = (state_q != IDLE);
    job_done       = (state_q == DONE) || zero_done_q;
    err_timeout    = err_timeout_q;
    err_col_count  = err_col_q;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      num_passes_q  <= '0;
      pass_q        <= '0;
      stride_q      <= '0;
      addr_q        <= '0;
      col_cnt_q     <= '0;
      conv_start_q  <= 1'b0;
      img_ack_q     <= 1'b0;
      soft_rst_q    <= 1'b0;
      zero_done_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      err_col_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      num_passes_q  <= num_passes_d;
      pass_q        <= pass_d;
      stride_q      <= stride_d;
      addr_q        <= addr_d;
      col_cnt_q     <= col_cnt_d;
      conv_start_q  <= conv_start_d;
      img_ack_q     <= img_ack_d;
      soft_rst_q    <= soft_rst_d;
      zero_done_q   <= zero_done_d;
      err_timeout_q <= err_timeout_d;
      err_col_q     <= err_col_d;
    end
  end

endmodule

// File: tb/tb_conv_pass_scheduler.sv
// Directed + randomized bench for conv_pass_scheduler with a job-level
// reference model (expected column tags, addresses, handshake counts).
module tb_conv_pass_scheduler;

  localparam int OUT_COLS       = 24;
  localparam int MAX_PASSES     = 16;
  localparam int ADDR_W         = 12;
  localparam int TIMEOUT_CYCLES = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_start = 1'b0;
  logic        cmd_abort = 1'b0;
  logic [4:0]  cfg_num_passes = '0;
  logic [11:0] cfg_base_addr = '0;
  logic [11:0] cfg_pass_stride = '0;
  logic        img_valid = 1'b0;
  logic        img_ack;
  logic        conv_start;
  logic        conv_soft_rst;
  logic [11:0] conv_base_addr;
  logic        conv_valid_col = 1'b0;
  logic        conv_done = 1'b0;
  logic        col_we;
  logic [4:0]  col_idx;
  logic [3:0]  pass_idx;
  logic        busy;
  logic        job_done;
  logic        err_timeout;
  logic        err_col_count;

  int checks = 0;
  int failures = 0;

  // Monitor results (written only by the monitor).
  logic [8:0] we_log[$];
  int start_cnt = 0;
  int ack_cnt = 0;
  int done_cnt = 0;

  int cols_cfg[16];

  conv_pass_scheduler #(
    .OUT_COLS       (OUT_COLS),
    .MAX_PASSES     (MAX_PASSES),
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_start       (cmd_start),
    .cmd_abort       (cmd_abort),
    .cfg_num_passes  (cfg_num_passes),
    .cfg_base_addr   (cfg_base_addr),
    .cfg_pass_stride (cfg_pass_stride),
    .img_valid       (img_valid),
    .img_ack         (img_ack),
    .conv_start      (conv_start),
    .conv_soft_rst   (conv_soft_rst),
    .conv_base_addr  (conv_base_addr),
    .conv_valid_col  (conv_valid_col),
    .conv_done       (conv_done),
    .col_we          (col_we),
    .col_idx         (col_idx),
    .pass_idx        (pass_idx),
    .busy            (busy),
    .job_done        (job_done),
    .err_timeout     (err_timeout),
    .err_col_count   (err_col_count)
  );

  always #5 clk = ~clk;

  // Sample outputs mid-cycle, after inputs and combinational paths settle.
  always @(negedge clk) begin
    if (!rst) begin
      if (col_we) we_log.push_back({pass_idx, col_idx});
      if (conv_start) start_cnt++;
      if (img_ack) ack_cnt++;
      if (job_done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output bit ok);
    int i;
    ok = 1'b0;
    i = 0;
    while (!ok && i < 64) begin
      if (conv_start === 1'b1) ok = 1'b1;
      else begin
        step();
        i++;
      end
    end
  endtask

  // Core model: ncols strobes with random gaps, done separate or coincident.
  task automatic core_pass(input int ncols, input bit coinc);
    int gap;
    for (int c = 0; c < ncols; c++) begin
      gap = int'($urandom_range(0, 2));
      repeat (gap) step();
      conv_valid_col = 1'b1;
      conv_done = coinc && (c == ncols - 1);
      #1;
      chk("col_we_strobe", 32'(col_we), 32'(c < OUT_COLS));
      step();
      conv_valid_col = 1'b0;
      conv_done = 1'b0;
    end
    if (!coinc || ncols == 0) begin
      conv_done = 1'b1;
      step();
      conv_done = 1'b0;
    end
  endtask

  task automatic run_job(input int n, input logic [11:0] base, input logic [11:0] stride,
                         input int delay, input bit coinc, input bit poke);
    int we0, st0, ack0, dn0, total, k;
    bit ok, exp_err;
    logic [11:0] exp_addr;
    we0 = we_log.size();
    st0 = start_cnt;
    ack0 = ack_cnt;
    dn0 = done_cnt;
    img_valid = (delay == 0);
    cfg_num_passes = 5'(n);
    cfg_base_addr = base;
    cfg_pass_stride = stride;
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    cfg_base_addr = 12'($urandom);
    cfg_pass_stride = 12'($urandom);
    chk("busy_after_start", 32'(busy), 32'(1));
    chk("errcol_cleared_on_start", 32'(err_col_count), 32'(0));
    if (delay == 0) begin
      chk("conv_start_t1", 32'(conv_start), 32'(0));
      step();
      chk("conv_start_t2", 32'(conv_start), 32'(1));
    end else begin
      for (int i = 0; i < delay; i++) begin
        step();
        chk("no_start_img_low", 32'(conv_start), 32'(0));
      end
      chk("start_cnt_img_low", 32'(start_cnt - st0), 32'(0));
      img_valid = 1'b1;
    end
    for (int p = 0; p < n; p++) begin
      wait_start(ok);
      chk("conv_start_seen", 32'(ok), 32'(1));
      exp_addr = 12'((32'(base) + 32'(p) * 32'(stride)) & 32'hFFF);
      chk("conv_base_addr", 32'(conv_base_addr), 32'(exp_addr));
      if (poke && p == 0) begin
        cfg_num_passes = 5'd5;
        cfg_base_addr = 12'hABC;
        cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
      end
      core_pass(cols_cfg[p], coinc);
    end
    repeat (3) step();
    // Reference model for the whole job.
    total = 0;
    exp_err = 1'b0;
    for (int p = 0; p < n; p++) begin
      total += (cols_cfg[p] < OUT_COLS) ? cols_cfg[p] : OUT_COLS;
      if (cols_cfg[p] != OUT_COLS) exp_err = 1'b1;
    end
    chk("col_we_total", 32'(we_log.size() - we0), 32'(total));
    if (we_log.size() - we0 == total) begin
      k = we0;
      for (int p = 0; p < n; p++) begin
        for (int c = 0; c < cols_cfg[p] && c < OUT_COLS; c++) begin
          chk("col_tag", 32'(we_log[k]), 32'({p[3:0], c[4:0]}));
          k++;
        end
      end
    end
    chk("conv_start_count", 32'(start_cnt - st0), 32'(n));
    chk("img_ack_count", 32'(ack_cnt - ack0), 32'(n));
    chk("job_done_count", 32'(done_cnt - dn0), 32'(1));
    chk("err_col_count", 32'(err_col_count), 32'(exp_err));
    chk("err_timeout_idle", 32'(err_timeout), 32'(0));
    chk("busy_end", 32'(busy), 32'(0));
  endtask

  initial begin
    int st0, dn0, n;
    bit ok, coinc;

    // Reset state.
    rst = 1'b1;
    repeat (3) step();
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_outputs", 32'({img_ack, conv_start, conv_soft_rst, col_we, job_done, err_timeout, err_col_count}), 32'(0));
    chk("rst_addr", 32'(conv_base_addr), 32'(0));
    chk("rst_idx", 32'({pass_idx, col_idx}), 32'(0));
    rst = 1'b0;
    step();

    // Nominal two-pass job.
    cols_cfg[0] = 24; cols_cfg[1] = 24;
    run_job(2, 12'h100, 12'h040, 0, 1'b0, 1'b0);

    // Short pass: 23 columns.
    cols_cfg[0] = 23;
    run_job(1, 12'h200, 12'h010, 0, 1'b0, 1'b0);

    // Zero-pass job: immediate job_done, no start; clears column error.
    st0 = start_cnt;
    cfg_num_passes = 5'd0;
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    chk("zero_job_done", 32'(job_done), 32'(1));
    chk("zero_busy", 32'(busy), 32'(0));
    chk("zero_errcol", 32'(err_col_count), 32'(0));
    step();
    chk("zero_job_done_pulse", 32'(job_done), 32'(0));
    chk("zero_no_start", 32'(start_cnt - st0), 32'(0));

    // Long pass: 25 columns.
    cols_cfg[0] = 25;
    run_job(1, 12'h300, 12'h000, 0, 1'b0, 1'b0);

    // Address wrap.
    cols_cfg[0] = 24; cols_cfg[1] = 24;
    run_job(2, 12'hFF0, 12'h020, 0, 1'b0, 1'b0);

    // img_valid late, cmd_start during RUN, coincident last column + done.
    cols_cfg[0] = 24; cols_cfg[1] = 24;
    run_job(1, 12'h050, 12'h008, 10, 1'b0, 1'b0);
    run_job(2, 12'h400, 12'h100, 0, 1'b0, 1'b1);
    run_job(1, 12'h123, 12'h001, 0, 1'b1, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 4; j++) begin
      n = int'($urandom_range(1, 3));
      coinc = 1'($urandom_range(0, 1));
      for (int p = 0; p < n; p++) cols_cfg[p] = int'($urandom_range(22, 26));
      run_job(n, 12'($urandom), 12'($urandom), 0, coinc, 1'b0);
    end

    // Watchdog: silent core.
    st0 = start_cnt;
    dn0 = done_cnt;
    img_valid = 1'b1;
    cfg_num_passes = 5'd2;
    cfg_base_addr = 12'h080;
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    wait_start(ok);
    chk("wd_conv_start_seen", 32'(ok), 32'(1));
    repeat (TIMEOUT_CYCLES - 1) step();
    chk("wd_not_yet", 32'(err_timeout), 32'(0));
    step();
    chk("wd_err_timeout", 32'(err_timeout), 32'(1));
    chk("wd_busy", 32'(busy), 32'(1));
    repeat (5) step();
    chk("wd_no_restart", 32'(start_cnt - st0), 32'(1));
    chk("wd_err_sticky", 32'(err_timeout), 32'(1));
    cmd_abort = 1'b1;
    step();
    cmd_abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_soft_rst", 32'(conv_soft_rst), 32'(1));
    chk("abort_err_cleared", 32'(err_timeout), 32'(0));
    chk("abort_no_ack_done", 32'({img_ack, job_done}), 32'(0));
    step();
    chk("abort_soft_rst_pulse", 32'(conv_soft_rst), 32'(0));
    chk("abort_no_job_done", 32'(done_cnt - dn0), 32'(0));

    // Reset in the middle of a job.
    cfg_num_passes = 5'd2;
    cfg_base_addr = 12'h300;
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    wait_start(ok);
    chk("midrst_start_seen", 32'(ok), 32'(1));
    repeat (5) begin
      conv_valid_col = 1'b1;
      step();
    end
    conv_valid_col = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_addr", 32'(conv_base_addr), 32'(0));
    chk("midrst_idx", 32'({pass_idx, col_idx}), 32'(0));
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
